// File: rtl/do_sel_pkg.sv
// Shared defaults, working width and golden evaluator for the do_sel block.
package do_sel_pkg;

  localparam logic [11:0] CONST_DEF = 12'd201;
  localparam int unsigned REP_DEF   = 7;
  localparam logic [1:0]  MASK_DEF  = 2'h2;
  localparam int unsigned SHIFT_DEF = 15;

  // Working width: REP copies of a 3-bit field above a 12-bit constant.
  localparam int unsigned W = 3 * REP_DEF + 12;

  // Result of one sample at the default parameters, full-width expression.
  function automatic logic [1:0] do_sel_eval(input logic in0, input logic [7:0] in4);
    logic [W-1:0] t_word;
    logic [W-1:0] f_word;
    logic [W-1:0] r_word;
    logic         unused_bits;
    t_word = {{REP_DEF{in4[3:1]}}, CONST_DEF} & {{(W-2){1'b0}}, MASK_DEF};
    f_word = {{(W-1){1'b0}}, ~in0} >> SHIFT_DEF;
    r_word = in4[0] ? t_word : f_word;
    unused_bits = ^{in4[7:4], r_word[W-1:2]};
    return r_word[1:0];
  endfunction

endpackage

// File: rtl/do_sel_if.sv
// Sample/result bundle for do_sel; clock and reset stay outside.
interface do_sel_if;

  logic              in_valid;
  logic              in0;
  logic signed [7:0] in4;
  logic              out_valid;
  logic [1:0]        res;
  logic              out20;

  modport master (
    output in_valid, in0, in4,
    input  out_valid, res, out20
  );

  modport slave (
    input  in_valid, in0, in4,
    output out_valid, res, out20
  );

endinterface

// File: rtl/do_sel_core.sv
// Combinational evaluator: true/false word generation, select, truncation.
module do_sel_core
  import do_sel_pkg::*;
#(
  parameter logic [11:0] CONST = CONST_DEF,
  parameter int unsigned REP   = REP_DEF,
  parameter logic [1:0]  MASK  = MASK_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic       in0,
  input  logic [7:0] in4,
  output logic [1:0] res
);

  localparam int unsigned WC = 3 * REP + 12;

  logic [WC-1:0] t_word;
  logic [WC-1:0] f_word;
  logic [WC-1:0] r_word;
  logic          unused_bits;

  // Build both candidate words at full width and pick one by in4[0].
  always_comb begin
    t_word = {{REP{in4[3:1]}}, CONST} & {{(WC-2){1'b0}}, MASK};
    // A 1-bit value shifted logically by any nonzero amount is zero, so the
    // shift collapses to a compile-time choice (also covers SHIFT >= WC).
    f_word = (SHIFT == 0) ? {{(WC-1){1'b0}}, ~in0} : '0;
    r_word = in4[0] ? t_word : f_word;
    res    = r_word[1:0];
  end

  assign unused_bits = ^{in4[7:4], r_word[WC-1:2]};

endmodule

// File: rtl/do_sel.sv
// Registered select-and-mask unit: input qualification and output flops.
module do_sel
  import do_sel_pkg::*;
#(
  parameter logic [11:0] CONST = CONST_DEF,
  parameter int unsigned REP   = REP_DEF,
  parameter logic [1:0]  MASK  = MASK_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  do_sel_if.slave  bus
);

  logic [1:0] core_res;
  logic [1:0] res_d;
  logic [1:0] res_q;
  logic       valid_d;
  logic       valid_q;

  do_sel_core #(
    .CONST (CONST),
    .REP   (REP),
    .MASK  (MASK),
    .SHIFT (SHIFT)
  ) u_core (
    .in0 (bus.in0),
    .in4 (bus.in4),
    .res (core_res)
  );

  // Load a new result only for qualified samples; otherwise hold.
  always_comb begin
    valid_d = bus.in_valid;
    res_d   = res_q;
    if (bus.in_valid) res_d = core_res;
  end

  // Output flops with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.res       = res_q;
  assign bus.out20     = res_q[0];

endmodule

// File: tb/tb_do_sel.sv
// Directed self-checking bench for do_sel across four parameter sets.
module tb_do_sel;
  import do_sel_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  do_sel_if bus_def ();
  do_sel_if bus_m3 ();
  do_sel_if bus_s0 ();
  do_sel_if bus_s300 ();

  do_sel dut_def (.clk(clk), .rst_n(rst_n), .bus(bus_def));
  do_sel #(.MASK(2'h3)) dut_m3 (.clk(clk), .rst_n(rst_n), .bus(bus_m3));
  do_sel #(.SHIFT(0)) dut_s0 (.clk(clk), .rst_n(rst_n), .bus(bus_s0));
  do_sel #(.SHIFT(300)) dut_s300 (.clk(clk), .rst_n(rst_n), .bus(bus_s300));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic a0, input logic [7:0] a4);
    bus_def.in_valid  = v; bus_def.in0  = a0; bus_def.in4  = a4;
    bus_m3.in_valid   = v; bus_m3.in0   = a0; bus_m3.in4   = a4;
    bus_s0.in_valid   = v; bus_s0.in0   = a0; bus_s0.in4   = a4;
    bus_s300.in_valid = v; bus_s300.in0 = a0; bus_s300.in4 = a4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    #3;
    n_checks++;
    if ({bus_def.out_valid, bus_def.res, bus_def.out20} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_def: got %b required 0000", {bus_def.out_valid, bus_def.res, bus_def.out20});
    end
    n_checks++;
    if ({bus_m3.out_valid, bus_m3.res, bus_m3.out20} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_m3: got %b required 0000", {bus_m3.out_valid, bus_m3.res, bus_m3.out20});
    end
    n_checks++;
    if ({bus_s0.out_valid, bus_s0.res, bus_s0.out20} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_s0: got %b required 0000", {bus_s0.out_valid, bus_s0.res, bus_s0.out20});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); drive(1'b1, 1'b0, 8'hFE);
    @(negedge clk); drive(1'b0, 1'b0, 8'h00);
    #1; // sample between edges, after the loading edge
    n_checks++;
    if (bus_def.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_valid: got %b required 1", bus_def.out_valid);
    end
    n_checks++;
    if (bus_def.res !== 2'b00 || bus_def.out20 !== 1'b0) begin
      n_fail++; $display("FAIL single_res: got res=%b out20=%b required res=00 out20=0", bus_def.res, bus_def.out20);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_def.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_valid_drop: got %b required 0", bus_def.out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] a4;
    logic [1:0] e_def, e_m3, e_s0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 2; b++) begin
        a4 = 8'(a);
        @(negedge clk); drive(1'b1, b[0], a4);
        @(posedge clk); #1;
        e_def = do_sel_eval(b[0], a4);
        e_m3  = a4[0] ? 2'b01 : 2'b00;
        e_s0  = a4[0] ? 2'b00 : {1'b0, ~b[0]};
        n_checks++;
        if (bus_def.res !== e_def || bus_def.res !== 2'b00 || bus_def.out20 !== 1'b0 || bus_def.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL sweep_def in4=%h in0=%0d: got res=%b out20=%b v=%b required res=00 out20=0 v=1",
                             a4, b, bus_def.res, bus_def.out20, bus_def.out_valid);
        end
        n_checks++;
        if (bus_m3.res !== e_m3 || bus_m3.out20 !== e_m3[0]) begin
          n_fail++; $display("FAIL sweep_m3 in4=%h in0=%0d: got res=%b out20=%b required res=%b", a4, b, bus_m3.res, bus_m3.out20, e_m3);
        end
        n_checks++;
        if (bus_s0.res !== e_s0 || bus_s0.out20 !== e_s0[0]) begin
          n_fail++; $display("FAIL sweep_s0 in4=%h in0=%0d: got res=%b out20=%b required res=%b", a4, b, bus_s0.res, bus_s0.out20, e_s0);
        end
        n_checks++;
        if (bus_s300.res !== 2'b00 || bus_s300.out20 !== 1'b0) begin
          n_fail++; $display("FAIL sweep_s300 in4=%h in0=%0d: got res=%b required 00", a4, b, bus_s300.res);
        end
      end
    end
  endtask

  task automatic test_mask();
    @(negedge clk); drive(1'b1, 1'b0, 8'h01);
    @(posedge clk); #1;
    n_checks++;
    if (bus_m3.res !== 2'b01 || bus_m3.out20 !== 1'b1) begin
      n_fail++; $display("FAIL mask_01: got res=%b out20=%b required res=01 out20=1", bus_m3.res, bus_m3.out20);
    end
    @(negedge clk); drive(1'b1, 1'b1, 8'h0F);
    @(posedge clk); #1;
    n_checks++;
    if (bus_m3.res !== 2'b01 || bus_m3.out20 !== 1'b1) begin
      n_fail++; $display("FAIL mask_0f: got res=%b out20=%b required res=01 out20=1", bus_m3.res, bus_m3.out20);
    end
  endtask

  task automatic test_shift();
    @(negedge clk); drive(1'b1, 1'b0, 8'hFE);
    @(posedge clk); #1;
    n_checks++;
    if (bus_s0.res !== 2'b01 || bus_s0.out20 !== 1'b1) begin
      n_fail++; $display("FAIL shift0_in0_0: got res=%b out20=%b required res=01 out20=1", bus_s0.res, bus_s0.out20);
    end
    n_checks++;
    if (bus_s300.res !== 2'b00 || bus_s300.out20 !== 1'b0) begin
      n_fail++; $display("FAIL shift300_in0_0: got res=%b out20=%b required res=00 out20=0", bus_s300.res, bus_s300.out20);
    end
    @(negedge clk); drive(1'b1, 1'b1, 8'hFE);
    @(posedge clk); #1;
    n_checks++;
    if (bus_s0.res !== 2'b00 || bus_s0.out20 !== 1'b0) begin
      n_fail++; $display("FAIL shift0_in0_1: got res=%b out20=%b required res=00 out20=0", bus_s0.res, bus_s0.out20);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b1, 1'b0, 8'h01);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_m3.res !== 2'b01 || bus_m3.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got res=%b v=%b required res=01 v=1", bus_m3.res, bus_m3.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_m3.out_valid, bus_m3.res, bus_m3.out20} !== 4'b0000) begin
      n_fail++; $display("FAIL areset_clear: got %b required 0000", {bus_m3.out_valid, bus_m3.res, bus_m3.out20});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus_m3.out_valid, bus_m3.res, bus_m3.out20} !== 4'b0000) begin
      n_fail++; $display("FAIL areset_held: got %b required 0000", {bus_m3.out_valid, bus_m3.res, bus_m3.out20});
    end
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b0, 8'h01);
    @(posedge clk); #1;
    n_checks++;
    if ({bus_m3.out_valid, bus_m3.res, bus_m3.out20} !== 4'b1011) begin
      n_fail++; $display("FAIL areset_first: got %b required 1011", {bus_m3.out_valid, bus_m3.res, bus_m3.out20});
    end
  endtask

  task automatic test_hold();
    @(negedge clk); drive(1'b1, 1'b0, 8'h01);
    @(posedge clk); #1;
    n_checks++;
    if (bus_m3.res !== 2'b01) begin
      n_fail++; $display("FAIL hold_setup: got res=%b required 01", bus_m3.res);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b0, 1'b1, 8'hFE);
      @(posedge clk); #1;
      n_checks++;
      if ({bus_m3.out_valid, bus_m3.res, bus_m3.out20} !== 4'b0011) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %b required 0011", i, {bus_m3.out_valid, bus_m3.res, bus_m3.out20});
      end
      n_checks++;
      if (bus_s0.res !== 2'b00 || bus_s0.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL hold_s0_cycle%0d: got res=%b v=%b required res=00 v=0", i, bus_s0.res, bus_s0.out_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_sweep();
    test_mask();
    test_shift();
    test_async_reset();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/do_sel.md
# do_sel

Registered select-and-mask unit. Each accepted sample produces a 2-bit result `res` and its LSB `out20`. A sample is the 1-bit flag `in0` plus the signed byte `in4`. Bit 0 of `in4` chooses between two sources: a replicated/masked constant word, or a shifted logical-NOT of `in0`. The block is a leaf in the datapath, and the bench checks it against a golden expression model. With default parameters every result is zero, so the block also serves as a width/shift-semantics regression target.

## Interface
- `CONST`, default 201: 12-bit constant forming the low field of the true-branch word.
- `REP`, default 7: replication count of `in4[3:1]` above the constant field (≥1).
- `MASK`, default 2'h2: mask ANDed with the true-branch word, zero-extended.
- `SHIFT`, default 15: logical right-shift amount applied to `!in0` (0..511).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: sample qualifier.
- `in0` input 1: flag operand.
- `in4` input 8, signed: select/data operand.
- `out_valid` output 1: result qualifier.
- `res` output 2: registered result.
- `out20` output 1: `res[0]`, registered.

## Operation
- Working width: W = 3·REP + 12 (33 at defaults). All intermediate values are unsigned at W bits.
- True word T = {REP copies of `in4[3:1]`, CONST[11:0]} & zero_extend(MASK).
- False word F = zero_extend(!in0) >> SHIFT.
  - The shift is logical.
  - Any SHIFT ≥ 1 yields F = 0, including SHIFT ≥ W.
  - SHIFT = 0 yields F = !in0.
- Selection: R = `in4[0]` ? T : F.
- Output: `res` = R[1:0], and `out20` = R[0].
- Signedness of `in4` is ignored. No sign extension occurs anywhere.
- At defaults, CONST[1:0] = 01, so T[1:0] = 01 & 10 = 00. F is 0 because SHIFT = 15. Therefore `res` = 00 and `out20` = 0 for every input, including X-free inputs with any `in4`/`in0` combination.
- `in0`/`in4` are ignored while `in_valid` = 0.

## Timing
- Latency is 1 cycle. On a rising `clk` edge with `in_valid` = 1:
  - `res` and `out20` load the value computed from the current inputs.
  - `out_valid` goes to 1.
- On an edge with `in_valid` = 0:
  - `out_valid` goes to 0.
  - `res` and `out20` hold their last value.
- The block accepts back-to-back samples, one per cycle. There is no backpressure.
- Reset values: `out_valid` = 0, `res` = 00, `out20` = 0.
- Asserting `rst_n` low mid-stream clears all outputs immediately, without waiting for a clock edge. The in-flight sample is discarded. The first edge after deassertion behaves as a normal edge.
- Outputs come straight from flops. There is no combinational path from inputs to outputs.

## Structure
- Shared package `do_sel_pkg`:
  - Default parameter constants (`CONST`, `REP`, `MASK`, `SHIFT`).
  - Localparam W.
  - A pure function `do_sel_eval(in0, in4)` returning 2 bits. The bench's golden model reuses this function.
- One natural sub-module, `do_sel_core`: the combinational evaluator. It contains the T/F generation, the select, and the truncation.
- The top level `do_sel` holds only the input qualification and output flops.

## Test plan
1. Defaults, `in4` = 8'hFE, `in0` = 0, `in_valid` pulse → next cycle `out_valid` = 1, `res` = 00, `out20` = 0.
2. Defaults, sweep all 256 `in4` values × both `in0` values back-to-back → `out20` = 0 and `res` = 00 every cycle, with `out_valid` continuous.
3. MASK = 2'h3, `in4` = 8'h01 → `res` = 01, `out20` = 1. Repeat with `in4` = 8'h0F → still `res` = 01, since the replicated field sits above bit 11.
4. SHIFT = 0, `in4` = 8'hFE, `in0` = 0 → `res` = 01, `out20` = 1. With `in0` = 1 → `res` = 00. With SHIFT = 300 and `in0` = 0 → `res` = 00.
5. Stream with MASK = 2'h3, then drop `rst_n` mid-stream → `res` = 00, `out20` = 0, `out_valid` = 0 asynchronously. The first valid sample after release is correct after 1 cycle.
6. `in_valid` low for 3 cycles after a result of 01 → `res` holds 01 and `out_valid` = 0.
